// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    localparam int SW = IW + 1;

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic          found;
    logic [SW-1:0] sum;

    always_comb begin
        // Rotating the doubled vector puts requester ptr at bit 0.
        rot   = N'({req, req} >> ptr);
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                off   = IW'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        winner = sum[IW-1:0];
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// granting one producer at a time for a burst of at most MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  WIDTH     = 32,
    parameter int  MAX_BURST = 4,
    localparam int GW        = clog2_min1(N_REQ),
    localparam int BW        = clog2_min1(MAX_BURST)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_wr_en,
    output logic [WIDTH-1:0]       fifo_wr_data,
    input  logic                   fifo_full,
    output logic                   grant_valid,
    output logic [GW-1:0]          grant_id,
    output arb_state_t             dbg_state,
    output logic [GW-1:0]          dbg_rr_ptr,
    output logic [BW-1:0]          dbg_beat_cnt
);

    // Handshake: a beat moves from requester i when req_valid[i] and req_ready[i]
    // are both high at a rising clk edge; the requester holds req_data/req_last
    // stable while valid and not ready, and ready never depends on anything but
    // the grant and fifo_full, so no combinational loop back to the producer.

    arb_state_t     state;
    logic [GW-1:0]  rr_ptr;
    logic [BW-1:0]  beat_cnt;

    logic [GW-1:0]  winner;
    logic           any_req;

    logic           in_burst;
    logic           g_valid;
    logic           g_last;
    logic [WIDTH-1:0] g_data;
    logic           xfer;

    rr_picker #(
        .N  (N_REQ),
        .IW (GW)
    ) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Select the granted requester's lane.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_burst = (state == ARB_BURST);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_burst && !fifo_full && grant_id == GW'(i)) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // The write data is forced to zero outside a grant so idle cycles are clean.
    assign fifo_wr_en   = in_burst & g_valid & ~fifo_full;
    assign fifo_wr_data = in_burst ? g_data : '0;
    assign xfer         = fifo_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        rr_ptr   <= (winner == GW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                        beat_cnt <= '0;
                        state    <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (!g_valid) begin
                        state <= ARB_IDLE;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (g_last || beat_cnt == BW'(MAX_BURST - 1)) begin
                            state <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign grant_valid  = in_burst;
    assign dbg_state    = state;
    assign dbg_rr_ptr   = rr_ptr;
    assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queued producers, an expected-write scoreboard
// and a monitor that checks every FIFO write against it.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;
    localparam int GW        = 2;
    localparam int BW        = 2;
    localparam int EW        = GW + WIDTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_wr_data;
    logic                   fifo_full;
    logic                   grant_valid;
    logic [GW-1:0]          grant_id;
    arb_state_t             dbg_state;
    logic [GW-1:0]          dbg_rr_ptr;
    logic [BW-1:0]          dbg_beat_cnt;

    int vectors  = 0;
    int fails    = 0;
    int cyc      = 0;
    int wr_count = 0;
    int wr_stamp[$];
    logic [EW-1:0]    exp_q[$];
    logic [WIDTH:0]   src_q[N_REQ][$];

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .dbg_state    (dbg_state),
        .dbg_rr_ptr   (dbg_rr_ptr),
        .dbg_beat_cnt (dbg_beat_cnt)
    );

    // Clock and cycle counter
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] beat_data(input int id, input int tag, input int k);
        return {8'(id), 8'(tag), 16'(k)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int id, input int tag, input int k, input bit last);
        src_q[id].push_back({1'(last), beat_data(id, tag, k)});
    endtask

    task automatic expect_beat(input int id, input int tag, input int k);
        exp_q.push_back({GW'(id), beat_data(id, tag, k)});
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic after_pos();
        @(posedge clk);
        #2;
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < N_REQ; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_writes(input string name, input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            at_neg();
            n++;
        end
        check({name, "_write_timeout"}, 64'(wr_count >= target), 64'(1));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            at_neg();
            n++;
            done = !grant_valid && src_empty() && exp_q.size() == 0;
        end
        check({name, "_idle_timeout"}, 64'(done), 64'(1));
    endtask

    function automatic int stamp_diff(input int a, input int b);
        if (wr_stamp.size() <= a || wr_stamp.size() <= b) return -1;
        return wr_stamp[b] - wr_stamp[a];
    endfunction

    // Producer driver: pop beats that handshook at the last edge, then present the next
    initial begin
        logic [N_REQ-1:0] fire;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (!rst && fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                req_valid[i] = (src_q[i].size() != 0);
                req_data[i*WIDTH +: WIDTH] = (src_q[i].size() != 0) ? src_q[i][0][WIDTH-1:0] : '0;
                req_last[i]  = (src_q[i].size() != 0) ? src_q[i][0][WIDTH] : 1'b0;
            end
        end
    end

    // Monitor and scoreboard
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (fifo_wr_en) begin
                vectors = vectors + 1;
                if (exp_q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL unexpected_write: got id %0d data %0h expected no write",
                             grant_id, fifo_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant_id, fifo_wr_data} !== e) begin
                        fails = fails + 1;
                        $display("FAIL write_data: got id %0d data %0h expected id %0d data %0h",
                                 grant_id, fifo_wr_data, e[EW-1:WIDTH], e[WIDTH-1:0]);
                    end
                end
                vectors = vectors + 1;
                if (fifo_full !== 1'b0) begin
                    fails = fails + 1;
                    $display("FAIL write_while_full: got fifo_full %b expected 0", fifo_full);
                end
                wr_count = wr_count + 1;
                wr_stamp.push_back(cyc);
            end
        end
    end

    // Directed stimulus
    initial begin
        int b;
        int base;
        rst       = 1'b1;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        at_neg();
        check("rst_grant_valid", 64'(grant_valid), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check("rst_wr_data", 64'(fifo_wr_data), 64'(0));
        check("rst_rr_ptr", 64'(dbg_rr_ptr), 64'(0));
        check("rst_beat_cnt", 64'(dbg_beat_cnt), 64'(0));

        // Fairness: everyone valid, bursts capped at 4, grants 0,1,2,3,0
        b = wr_stamp.size();
        for (int id = 0; id < N_REQ; id++)
            for (int k = 0; k < 4; k++) push_beat(id, 1, k, 1'b0);
        push_beat(0, 1, 4, 1'b1);
        for (int id = 0; id < N_REQ; id++)
            for (int k = 0; k < 4; k++) expect_beat(id, 1, k);
        expect_beat(0, 1, 4);
        wait_idle("fair", 80);
        check("fair_16_write_span", 64'(stamp_diff(b, b + 15)), 64'(18));
        check("fair_bubble", 64'(stamp_diff(b + 3, b + 4)), 64'(2));
        check("fair_rr_ptr", 64'(dbg_rr_ptr), 64'(1));

        // Packet end: last on beat 2 closes the burst, next packet needs a new grant
        b = wr_stamp.size();
        push_beat(2, 2, 0, 1'b0);
        push_beat(2, 2, 1, 1'b1);
        push_beat(2, 2, 2, 1'b1);
        expect_beat(2, 2, 0);
        expect_beat(2, 2, 1);
        expect_beat(2, 2, 2);
        wait_idle("pkt", 40);
        check("pkt_back_to_back", 64'(stamp_diff(b, b + 1)), 64'(1));
        check("pkt_gap_after_last", 64'(stamp_diff(b + 1, b + 2)), 64'(2));
        check("pkt_rr_ptr", 64'(dbg_rr_ptr), 64'(3));

        // Backpressure: full for 3 cycles after two beats of req 1
        base = wr_count;
        for (int k = 0; k < 4; k++) push_beat(1, 3, k, 1'b0);
        for (int k = 0; k < 4; k++) expect_beat(1, 3, k);
        wait_writes("bp", base + 2, 20);
        after_pos();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            at_neg();
            check("bp_wr_en", 64'(fifo_wr_en), 64'(0));
            check("bp_req_ready", 64'(req_ready), 64'(0));
            check("bp_grant_held", 64'(grant_valid), 64'(1));
            check("bp_grant_id", 64'(grant_id), 64'(1));
            check("bp_beat_cnt", 64'(dbg_beat_cnt), 64'(2));
        end
        after_pos();
        fifo_full = 1'b0;
        wait_idle("bp", 40);
        check("bp_rr_ptr", 64'(dbg_rr_ptr), 64'(2));

        // Release: req 2 drops valid after one beat, req 3 is next upward
        b = wr_stamp.size();
        push_beat(2, 4, 0, 1'b0);
        push_beat(3, 4, 0, 1'b0);
        push_beat(3, 4, 1, 1'b1);
        expect_beat(2, 4, 0);
        expect_beat(3, 4, 0);
        expect_beat(3, 4, 1);
        wait_idle("rel", 40);
        check("rel_gap", 64'(stamp_diff(b, b + 1)), 64'(3));
        check("rel_rr_ptr", 64'(dbg_rr_ptr), 64'(0));

        // Wrap: move rr_ptr to 3, then only reqs 0 and 3 compete
        push_beat(2, 5, 0, 1'b1);
        expect_beat(2, 5, 0);
        wait_idle("wrap_setup", 20);
        check("wrap_setup_rr_ptr", 64'(dbg_rr_ptr), 64'(3));
        push_beat(0, 5, 0, 1'b1);
        push_beat(0, 5, 1, 1'b1);
        push_beat(3, 5, 0, 1'b1);
        push_beat(3, 5, 1, 1'b1);
        expect_beat(3, 5, 0);
        expect_beat(0, 5, 0);
        expect_beat(3, 5, 1);
        expect_beat(0, 5, 1);
        wait_idle("wrap", 40);
        check("wrap_rr_ptr", 64'(dbg_rr_ptr), 64'(1));

        // Reset mid-burst: only beat 0 is written before rst, the rest after
        base = wr_count;
        for (int k = 0; k < 4; k++) push_beat(0, 6, k, 1'b0);
        expect_beat(0, 6, 0);
        wait_writes("mrst", base + 1, 20);
        after_pos();
        rst = 1'b1;
        #1;
        check("mrst_grant_valid", 64'(grant_valid), 64'(0));
        check("mrst_req_ready", 64'(req_ready), 64'(0));
        check("mrst_wr_en", 64'(fifo_wr_en), 64'(0));
        check("mrst_wr_data", 64'(fifo_wr_data), 64'(0));
        check("mrst_state", 64'(dbg_state), 64'(ARB_IDLE));
        for (int k = 1; k < 4; k++) expect_beat(0, 6, k);
        after_pos();
        rst = 1'b0;
        #1;
        check("mrst_grant_id", 64'(grant_id), 64'(0));
        check("mrst_rr_ptr", 64'(dbg_rr_ptr), 64'(0));
        check("mrst_beat_cnt", 64'(dbg_beat_cnt), 64'(0));
        wait_idle("mrst", 40);

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among N_REQ producers. Each producer offers beats over a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and forwards its beats to the FIFO's wr_en/wr_data, throttled by the FIFO's full flag. It sits directly in front of the FIFO write side.

## Interface
- N_REQ, 4: number of requesters (2..16)
- WIDTH, 32: data width, matches FIFO WIDTH
- MAX_BURST, 4: max beats per grant (1..64)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*WIDTH  flattened data; requester i at bits [i*WIDTH +: WIDTH]
- req_last  in  N_REQ  beat is last of packet
- req_ready  out  N_REQ  per-requester accept
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  WIDTH  FIFO write data
- fifo_full  in  1  FIFO full flag
- grant_valid  out  1  a grant is held (state BURST)
- grant_id  out  GW  granted requester; GW = max(1, $clog2(N_REQ))

## Operation
- Clock is one domain (clk). Reset is asynchronous and active-high (rst).
- States:
  - ARB_IDLE: no grant held.
  - ARB_BURST: grant held by grant_id.
- ARB_IDLE, any req_valid high:
  - Winner is the first valid index searching upward from rr_ptr, wrapping modulo N_REQ.
  - Register grant_id = winner; rr_ptr <= (winner+1) mod N_REQ.
  - Clear beat_cnt; next state ARB_BURST.
- ARB_IDLE, no req_valid: stay; rr_ptr unchanged.
- ARB_BURST:
  - req_ready[grant_id] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & !fifo_full.
  - fifo_wr_data = slice grant_id of req_data (combinational).
- Transfer = req_valid[grant_id] & req_ready[grant_id]. On each transfer beat_cnt increments.
- ARB_BURST -> ARB_IDLE when any of:
  - a transfer with req_last[grant_id]=1;
  - a transfer with beat_cnt == MAX_BURST-1 (cap reached);
  - req_valid[grant_id]=0 (requester released; nothing transferred that cycle).
- fifo_full=1 during BURST: grant is held, no transfer, beat_cnt frozen; resume when full drops.
- In ARB_IDLE, req_ready = 0 and fifo_wr_en = 0.
- Requester duty: hold req_data/req_last stable while valid and not ready. The arbiter never writes the FIFO when fifo_full=1.

## Timing
- Reset values:
  - state ARB_IDLE, grant_valid 0, grant_id 0, rr_ptr 0, beat_cnt 0.
  - Therefore req_ready 0, fifo_wr_en 0, fifo_wr_data 0.
- rst asserted mid-burst: grant drops immediately (async). Any beat in flight that cycle is not written.
- Arbitration latency: request seen in IDLE at edge t; grant_valid high after t; first beat can transfer in cycle t+1.
- Grant-to-grant bubble: one IDLE cycle. Peak throughput = MAX_BURST/(MAX_BURST+1) beats/cycle.
- Data path is combinational from req_* to fifo_wr_*; no added write latency.
- beat_cnt width is max(1, $clog2(MAX_BURST)). rr_ptr width is GW, wraps N_REQ-1 -> 0 for non-power-of-2 N_REQ.
- MAX_BURST=1: every transfer returns to IDLE.

## Structure
- Package fifo_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_BURST};
  - function clog2_min1.
- Sub-module rr_picker: combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_req.
  - Implemented by double-width rotate and priority encode.

## Test plan
- Reset: assert rst mid-burst with req_valid=4'b0001 -> grant_valid, req_ready, fifo_wr_en all 0 within same cycle; grant_id=0 after release.
- Fairness: all 4 requesters continuously valid, no last, MAX_BURST=4, fifo_full=0 -> grants 0,1,2,3,0 in sequence; 4 writes each then one idle cycle; 16 writes in 20 cycles.
- Packet end: req 2 sends 2 beats with last on beat 2 -> exactly 2 FIFO writes tagged data of req 2, return to IDLE, rr_ptr=3.
- Backpressure: fifo_full=1 for 3 cycles mid-burst -> fifo_wr_en=0, req_ready=0 and grant held those cycles; beat_cnt unchanged; burst completes after full drops.
- Release: granted requester drops req_valid after 1 beat -> IDLE next cycle; next valid requester upward from rr_ptr is granted.
- Wrap: only req 0 and req 3 valid, rr_ptr=3 -> grant 3, then 0, then 3.
